// File: rtl/column_buffer.sv
// column_buffer: per-column wall store for a raycaster display.
// The tracer writes {side, height} per screen column; the display side reads
// the entry for the current hpos and classifies the pixel as sky, wall or floor.
// Build option: define COLUMN_BUFFER_DBUF_EN for a double-buffered (two-bank)
// store flipped by the swap pulse; undefined gives a single shared bank.
module column_buffer #(
  parameter int COLS = 640,
  parameter int MID  = 240
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       store,
  input  logic [9:0] column,
  input  logic       side,
  input  logic [7:0] height,
  input  logic [9:0] hpos,
  input  logic [9:0] vpos,
  input  logic       swap,
  output logic       busy,
  output logic [1:0] pix_class,
  output logic       pix_side,
  output logic [9:0] stored_count
);

`ifdef COLUMN_BUFFER_DBUF_EN
  localparam int BANKS = 2;
`else
  localparam int BANKS = 1;
`endif
  localparam int ENTRIES = BANKS * COLS;
  localparam int AW      = $clog2(ENTRIES);

  typedef enum logic {CLEAR, RUN} state_t;

  state_t        state;
  logic [AW-1:0] clr_addr;
  logic [8:0]    mem [ENTRIES];

  logic [AW-1:0] wr_base;
  logic [AW-1:0] rd_base;
  logic          accept;
  logic          wr_en;
  logic [AW-1:0] wr_idx;
  logic [8:0]    wr_data;
  logic [7:0]    clamped;
  logic          hpos_ok;
  logic [AW-1:0] rd_idx;
  logic [8:0]    rd_entry;
  logic [10:0]   lo;
  logic [10:0]   hi;
  logic [10:0]   v;
  logic [1:0]    next_class;

`ifdef COLUMN_BUFFER_DBUF_EN
  logic bank_sel;

  // Front bank is selected by bank_sel; writes always land in the other one.
  assign rd_base = bank_sel ? AW'(COLS) : '0;
  assign wr_base = bank_sel ? '0 : AW'(COLS);

  // Bank select flips on every swap pulse and returns to bank 0 on reset.
  always_ff @(posedge clk) begin
    if (reset) bank_sel <= 1'b0;
    else if (swap) bank_sel <= ~bank_sel;
  end
`else
  assign rd_base = '0;
  assign wr_base = '0;
`endif

  assign accept  = (state == RUN) && store && (column < 10'(COLS));
  assign clamped = (height > 8'(MID)) ? 8'(MID) : height;

  // Memory write port: sweep during CLEAR, tracer writes in RUN, nothing under reset.
  always_comb begin
    wr_en   = 1'b0;
    wr_idx  = clr_addr;
    wr_data = '0;
    if (!reset) begin
      if (state == CLEAR) begin
        wr_en = 1'b1;
      end else if (accept) begin
        wr_en   = 1'b1;
        wr_idx  = wr_base + AW'(column);
        wr_data = {side, clamped};
      end
    end
  end

  // Storage array; the read below sees the pre-edge contents (read-before-write).
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= wr_data;
  end

  // Two-state controller: CLEAR sweeps every entry once, then RUN.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= CLEAR;
      clr_addr <= '0;
      busy     <= 1'b1;
    end else if (state == CLEAR) begin
      if (clr_addr == AW'(ENTRIES - 1)) begin
        state <= RUN;
        busy  <= 1'b0;
      end else begin
        clr_addr <= clr_addr + 1'b1;
      end
    end
  end

  // Count of accepted writes since the last swap; a same-cycle write counts as the first.
  always_ff @(posedge clk) begin
    if (reset) stored_count <= '0;
    else if (swap) stored_count <= accept ? 10'd1 : 10'd0;
    else if (accept && stored_count != 10'h3FF) stored_count <= stored_count + 10'd1;
  end

  // Pixel classification from the front-bank entry at hpos against the wall span.
  always_comb begin
    hpos_ok  = hpos < 10'(COLS);
    rd_idx   = rd_base + AW'(hpos);
    rd_entry = hpos_ok ? mem[rd_idx] : '0;
    lo       = 11'(MID) - {3'b000, rd_entry[7:0]};
    hi       = 11'(MID) + {3'b000, rd_entry[7:0]};
    v        = {1'b0, vpos};
    if (v < lo) next_class = 2'd0;
    else if (v < hi) next_class = 2'd1;
    else next_class = 2'd2;
  end

  // Registered pixel outputs, forced to sky while clearing or off the right edge.
  always_ff @(posedge clk) begin
    if (reset || state == CLEAR || !hpos_ok) begin
      pix_class <= 2'd0;
      pix_side  <= 1'b0;
    end else begin
      pix_class <= next_class;
      pix_side  <= (next_class == 2'd1) ? rd_entry[8] : 1'b0;
    end
  end

endmodule
